instruction_fetch: RTL and testbench
====================================

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 64'h0, the PC fetched first after reset.
REQ-002 The block SHALL have parameter XLEN, default 64, the PC/address width.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 Stall  input  1  downstream IF_ID cannot accept; hold the current output.
REQ-006 Branch_Taken  input  1  redirect fetch and flush the output (from EX).
REQ-007 Branch_Target  input  XLEN  redirect address, valid when Branch_Taken=1.
REQ-008 IMem_Req  output  1  instruction memory read request.
REQ-009 IMem_Addr  output  XLEN  read address, equal to current PC.
REQ-010 IMem_Ready  input  1  memory returns IMem_Data this cycle; a transfer occurs when IMem_Req && IMem_Ready.
REQ-011 IMem_Data  input  32  fetched instruction word.
REQ-012 PC_Out  output  XLEN  PC of the instruction presented to IF_ID.
REQ-013 Instruction  output  32  instruction presented to IF_ID.
REQ-014 Fetch_Valid  output  1  PC_Out/Instruction hold a valid instruction.
REQ-015 Fetch_Fault  output  1  sticky misaligned-target fault.

Function
REQ-016 The FSM SHALL have states RUN, HOLD and FAULT.
REQ-017 IMem_Req SHALL be 1 only in RUN and only when (!Fetch_Valid || !Stall); IMem_Addr SHALL be PC at all times.
REQ-018 On a transfer with Branch_Taken=0, next cycle: Instruction<=IMem_Data, PC_Out<=PC, Fetch_Valid<=1, PC<=PC+4 (modulo 2^XLEN; 64'hFFFF_FFFF_FFFF_FFFC wraps to 0).
REQ-019 Fetch latency SHALL be one cycle from transfer to Fetch_Valid; with IMem_Ready tied high and Stall=0, one instruction SHALL be delivered per cycle.
REQ-020 When Fetch_Valid=1, Stall=0 and no transfer occurs, Fetch_Valid SHALL clear next cycle (output consumed).
REQ-021 RUN->HOLD when Fetch_Valid=1 && Stall=1 && Branch_Taken=0; in HOLD, outputs and PC SHALL be unchanged and IMem_Req=0.
REQ-022 HOLD->RUN when Stall=0; the held instruction is consumed that cycle.
REQ-023 Branch_Taken=1 SHALL override Stall and any same-cycle transfer: the response is discarded, Fetch_Valid<=0, PC<=Branch_Target, state<=RUN, from RUN or HOLD.
REQ-024 Branch_Taken=1 with Branch_Target[1:0]!=0 SHALL instead set Fetch_Fault<=1, Fetch_Valid<=0, state<=FAULT, PC unchanged.
REQ-025 In FAULT, IMem_Req=0 and Fetch_Valid=0, ignoring all inputs except reset.
REQ-026 A response without IMem_Req SHALL be ignored.

Reset
REQ-027 With reset=1 at a rising edge: PC<=RESET_PC, state<=RUN, Fetch_Valid<=0, Fetch_Fault<=0, PC_Out<=0, Instruction<=0 (32'h0), overriding every other input, including mid-stall and in FAULT.
REQ-028 IMem_Req SHALL be 0 while reset=1 and 1 (addr RESET_PC) in the first cycle after reset released.

Structure
REQ-029 XLEN, ILEN=32, the fetch-state enum and the NOP constant 32'h0000_0013 SHALL live in shared package riscv_pkg.
REQ-030 The PC register with its +4/redirect mux SHALL be sub-module pc_register; everything else stays in instruction_fetch.

Verification
REQ-031 Reset release, IMem_Ready=1, Stall=0 -> PC_Out sequence 0,4,8,12 on consecutive cycles with Fetch_Valid=1 from cycle 2.
REQ-032 IMem_Ready low 3 cycles at PC=8 -> IMem_Req/IMem_Addr=8 held, Fetch_Valid=0 after consuming prior word, then PC_Out=8 one cycle after Ready.
REQ-033 Stall=1 for 4 cycles with PC_Out=4 valid -> PC_Out=4, Instruction unchanged, IMem_Req=0; Stall=0 -> PC_Out=8 next.
REQ-034 Branch_Taken=1, Branch_Target=64'h100 during Stall and same-cycle transfer -> Fetch_Valid=0 next cycle, IMem_Addr=64'h100, then PC_Out=64'h100.
REQ-035 Branch_Target=64'h102 -> Fetch_Fault=1, IMem_Req=0 until reset; reset -> Fetch_Fault=0, IMem_Addr=RESET_PC.
REQ-036 PC=64'hFFFF_FFFF_FFFF_FFFC transfer -> next IMem_Addr=0.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end definitions: widths, fetch FSM states and the canonical NOP.
package riscv_pkg;

  localparam int unsigned XLEN = 64;
  localparam int unsigned ILEN = 32;

  localparam logic [ILEN-1:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    HOLD  = 2'd1,
    FAULT = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/instruction_fetch_if.sv
// Instruction-memory read channel between the fetch stage (master) and memory (slave).
interface instruction_fetch_if #(
  parameter int unsigned XLEN = riscv_pkg::XLEN
) ();

  logic                       IMem_Req;
  logic [XLEN-1:0]            IMem_Addr;
  logic                       IMem_Ready;
  logic [riscv_pkg::ILEN-1:0] IMem_Data;

  modport master (
    output IMem_Req,
    output IMem_Addr,
    input  IMem_Ready,
    input  IMem_Data
  );

  modport slave (
    input  IMem_Req,
    input  IMem_Addr,
    output IMem_Ready,
    output IMem_Data
  );

endinterface

// File: rtl/pc_register.sv
// Program counter with sequential +4 advance and branch redirect; redirect wins.
module pc_register #(
  parameter int unsigned     XLEN     = 64,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            advance_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] target_i,
  output logic [XLEN-1:0] pc_o
);

  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] pc_d;

  // Addition wraps naturally at 2^XLEN.
  always_comb begin
    pc_d = pc_q;
    if (redirect_i) begin
      pc_d = target_i;
    end else if (advance_i) begin
      pc_d = pc_q + XLEN'(4);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/instruction_fetch.sv
// Single-stage instruction fetch: issues reads at PC, registers the returned word for IF_ID,
// holds under Stall, redirects on taken branches and traps on misaligned targets.
module instruction_fetch #(
  parameter int unsigned     XLEN     = 64,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       Stall,
  input  logic                       Branch_Taken,
  input  logic [XLEN-1:0]            Branch_Target,
  instruction_fetch_if.master        imem,
  output logic [XLEN-1:0]            PC_Out,
  output logic [riscv_pkg::ILEN-1:0] Instruction,
  output logic                       Fetch_Valid,
  output logic                       Fetch_Fault
);

  import riscv_pkg::*;

  fetch_state_e    state_q;
  logic            valid_q;
  logic            fault_q;
  logic [XLEN-1:0] pc_out_q;
  logic [ILEN-1:0] instr_q;
  logic [XLEN-1:0] pc;

  logic misaligned_c;
  logic req_c;
  logic xfer_c;
  logic redirect_c;
  logic advance_c;

  // A new word may only be requested when the output slot is free or being drained.
  assign misaligned_c = (Branch_Target[1:0] != 2'b00);
  assign req_c        = !reset && (state_q == RUN) && (!valid_q || !Stall);
  assign xfer_c       = req_c && imem.IMem_Ready;
  assign redirect_c   = Branch_Taken && !misaligned_c && (state_q != FAULT);
  assign advance_c    = xfer_c && !Branch_Taken;

  pc_register #(
    .XLEN     (XLEN),
    .RESET_PC (RESET_PC)
  ) u_pc_register (
    .clk        (clk),
    .reset      (reset),
    .advance_i  (advance_c),
    .redirect_i (redirect_c),
    .target_i   (Branch_Target),
    .pc_o       (pc)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= RUN;
      valid_q  <= 1'b0;
      fault_q  <= 1'b0;
      pc_out_q <= '0;
      instr_q  <= '0;
    end else begin
      case (state_q)
        RUN, HOLD: begin
          if (Branch_Taken) begin
            // Branch flushes the slot and discards any same-cycle response.
            valid_q <= 1'b0;
            if (misaligned_c) begin
              fault_q <= 1'b1;
              state_q <= FAULT;
            end else begin
              state_q <= RUN;
            end
          end else if (state_q == HOLD) begin
            if (!Stall) begin
              valid_q <= 1'b0;
              state_q <= RUN;
            end
          end else if (xfer_c) begin
            instr_q  <= imem.IMem_Data;
            pc_out_q <= pc;
            valid_q  <= 1'b1;
          end else if (valid_q && Stall) begin
            state_q <= HOLD;
          end else begin
            valid_q <= 1'b0;
          end
        end
        FAULT: begin
          valid_q <= 1'b0;
        end
        default: begin
          valid_q <= 1'b0;
          state_q <= RUN;
        end
      endcase
    end
  end

  assign imem.IMem_Req  = req_c;
  assign imem.IMem_Addr = pc;
  assign PC_Out         = pc_out_q;
  assign Instruction    = instr_q;
  assign Fetch_Valid    = valid_q;
  assign Fetch_Fault    = fault_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: per-cycle vector table plus reset corner sequences.
module tb_instruction_fetch;

  localparam int unsigned XL = 64;
  localparam int NVEC = 26;

  logic          clk = 1'b0;
  logic          reset;
  logic          Stall;
  logic          Branch_Taken;
  logic [XL-1:0] Branch_Target;
  logic          ready;
  logic [XL-1:0] PC_Out;
  logic [31:0]   Instruction;
  logic          Fetch_Valid;
  logic          Fetch_Fault;

  int checks = 0;
  int errors = 0;

  instruction_fetch_if #(.XLEN(XL)) imem ();

  instruction_fetch #(
    .XLEN     (XL),
    .RESET_PC (64'h0)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .Stall         (Stall),
    .Branch_Taken  (Branch_Taken),
    .Branch_Target (Branch_Target),
    .imem          (imem.master),
    .PC_Out        (PC_Out),
    .Instruction   (Instruction),
    .Fetch_Valid   (Fetch_Valid),
    .Fetch_Fault   (Fetch_Fault)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [XL-1:0] a);
    return a[31:0] ^ 32'h1234_5670;
  endfunction

  // Memory model: answers whatever address is presented, gated by ready.
  always_comb begin
    imem.IMem_Data  = mem_word(imem.IMem_Addr);
    imem.IMem_Ready = ready;
  end

  typedef struct packed {
    logic          stall;
    logic          br;
    logic [XL-1:0] tgt;
    logic          rdy;
    logic          e_req;
    logic [XL-1:0] e_addr;
    logic          e_valid;
    logic [XL-1:0] e_pcout;
    logic          e_fault;
  } vec_t;

  vec_t vecs [NVEC];

  function automatic vec_t mk(input logic s, input logic b, input logic [XL-1:0] t, input logic r,
                              input logic q, input logic [XL-1:0] a, input logic v,
                              input logic [XL-1:0] p, input logic f);
    vec_t x;
    x.stall = s; x.br = b; x.tgt = t; x.rdy = r;
    x.e_req = q; x.e_addr = a; x.e_valid = v; x.e_pcout = p; x.e_fault = f;
    return x;
  endfunction

  task automatic chk(input string name, input logic [XL-1:0] act, input logic [XL-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic s, input logic b, input logic [XL-1:0] t,
                       input logic rd);
    reset = r; Stall = s; Branch_Taken = b; Branch_Target = t; ready = rd;
  endtask

  initial begin
    //            stall br  target                 rdy req addr                   vld pc_out                 flt
    vecs[0]  = mk(0, 0, 64'h0,                 1,  1, 64'h0,                 1, 64'h0,                 0);
    vecs[1]  = mk(0, 0, 64'h0,                 1,  1, 64'h4,                 1, 64'h4,                 0);
    vecs[2]  = mk(0, 0, 64'h0,                 1,  1, 64'h8,                 1, 64'h8,                 0);
    vecs[3]  = mk(0, 0, 64'h0,                 1,  1, 64'hC,                 1, 64'hC,                 0);
    vecs[4]  = mk(0, 0, 64'h0,                 0,  1, 64'h10,                0, 64'hC,                 0);
    vecs[5]  = mk(0, 0, 64'h0,                 0,  1, 64'h10,                0, 64'hC,                 0);
    vecs[6]  = mk(0, 0, 64'h0,                 0,  1, 64'h10,                0, 64'hC,                 0);
    vecs[7]  = mk(0, 0, 64'h0,                 1,  1, 64'h10,                1, 64'h10,                0);
    vecs[8]  = mk(1, 0, 64'h0,                 1,  0, 64'h14,                1, 64'h10,                0);
    vecs[9]  = mk(1, 0, 64'h0,                 1,  0, 64'h14,                1, 64'h10,                0);
    vecs[10] = mk(1, 0, 64'h0,                 1,  0, 64'h14,                1, 64'h10,                0);
    vecs[11] = mk(1, 0, 64'h0,                 1,  0, 64'h14,                1, 64'h10,                0);
    vecs[12] = mk(0, 0, 64'h0,                 1,  0, 64'h14,                0, 64'h10,                0);
    vecs[13] = mk(0, 0, 64'h0,                 1,  1, 64'h14,                1, 64'h14,                0);
    vecs[14] = mk(1, 0, 64'h0,                 1,  0, 64'h18,                1, 64'h14,                0);
    vecs[15] = mk(1, 1, 64'h100,               1,  0, 64'h18,                0, 64'h14,                0);
    vecs[16] = mk(0, 0, 64'h0,                 1,  1, 64'h100,               1, 64'h100,               0);
    vecs[17] = mk(0, 1, 64'h200,               1,  1, 64'h104,               0, 64'h100,               0);
    vecs[18] = mk(0, 0, 64'h0,                 1,  1, 64'h200,               1, 64'h200,               0);
    vecs[19] = mk(0, 1, 64'hFFFF_FFFF_FFFF_FFFC, 1, 1, 64'h204,              0, 64'h200,               0);
    vecs[20] = mk(0, 0, 64'h0,                 1,  1, 64'hFFFF_FFFF_FFFF_FFFC, 1, 64'hFFFF_FFFF_FFFF_FFFC, 0);
    vecs[21] = mk(0, 0, 64'h0,                 1,  1, 64'h0,                 1, 64'h0,                 0);
    vecs[22] = mk(0, 1, 64'h102,               1,  1, 64'h4,                 0, 64'h0,                 1);
    vecs[23] = mk(0, 1, 64'h300,               1,  0, 64'h4,                 0, 64'h0,                 1);
    vecs[24] = mk(0, 0, 64'h0,                 1,  0, 64'h4,                 0, 64'h0,                 1);
    vecs[25] = mk(1, 0, 64'h0,                 1,  0, 64'h4,                 0, 64'h0,                 1);

    // Power-on reset
    drive(1, 0, 0, '0, 1);
    @(negedge clk);
    chk("reset_req", XL'(imem.IMem_Req), XL'(0));
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("reset_valid", XL'(Fetch_Valid), XL'(0));
    chk("reset_fault", XL'(Fetch_Fault), XL'(0));
    chk("reset_pcout", PC_Out, 64'h0);
    chk("reset_instr", XL'(Instruction), XL'(0));

    for (int i = 0; i < NVEC; i++) begin
      @(negedge clk);
      drive(0, vecs[i].stall, vecs[i].br, vecs[i].tgt, vecs[i].rdy);
      #1;
      chk($sformatf("v%0d_req", i), XL'(imem.IMem_Req), XL'(vecs[i].e_req));
      chk($sformatf("v%0d_addr", i), imem.IMem_Addr, vecs[i].e_addr);
      @(posedge clk); #1;
      chk($sformatf("v%0d_valid", i), XL'(Fetch_Valid), XL'(vecs[i].e_valid));
      chk($sformatf("v%0d_pcout", i), PC_Out, vecs[i].e_pcout);
      chk($sformatf("v%0d_fault", i), XL'(Fetch_Fault), XL'(vecs[i].e_fault));
      if (vecs[i].e_valid)
        chk($sformatf("v%0d_instr", i), XL'(Instruction), XL'(mem_word(vecs[i].e_pcout)));
    end

    // Reset out of FAULT
    @(negedge clk);
    drive(1, 0, 0, '0, 1);
    #1;
    chk("fault_rst_req", XL'(imem.IMem_Req), XL'(0));
    @(posedge clk); #1;
    chk("fault_rst_fault", XL'(Fetch_Fault), XL'(0));
    chk("fault_rst_valid", XL'(Fetch_Valid), XL'(0));
    chk("fault_rst_pcout", PC_Out, 64'h0);
    chk("fault_rst_instr", XL'(Instruction), XL'(0));
    @(negedge clk);
    drive(0, 0, 0, '0, 1);
    #1;
    chk("post_rst_req", XL'(imem.IMem_Req), XL'(1));
    chk("post_rst_addr", imem.IMem_Addr, 64'h0);
    @(posedge clk); #1;
    chk("post_rst_valid", XL'(Fetch_Valid), XL'(1));

    // Reset while held under Stall
    @(negedge clk);
    drive(0, 1, 0, '0, 1);
    #1;
    chk("hold_req", XL'(imem.IMem_Req), XL'(0));
    @(posedge clk); #1;
    chk("hold_valid", XL'(Fetch_Valid), XL'(1));
    @(negedge clk);
    drive(1, 1, 0, '0, 1);
    @(posedge clk); #1;
    chk("hold_rst_valid", XL'(Fetch_Valid), XL'(0));
    chk("hold_rst_pcout", PC_Out, 64'h0);
    @(negedge clk);
    drive(0, 1, 0, '0, 1);
    #1;
    chk("hold_rel_req", XL'(imem.IMem_Req), XL'(1));
    chk("hold_rel_addr", imem.IMem_Addr, 64'h0);
    @(posedge clk); #1;
    chk("hold_rel_valid", XL'(Fetch_Valid), XL'(1));
    chk("hold_rel_instr", XL'(Instruction), XL'(mem_word(64'h0)));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
